// File: rtl/rtc_date_writer.sv
// rtc_date_writer: writes day/month/year BCD bytes to the RTC over the AD bus as three address/data cycles.
// Optional RTC_BCD_CHECK_EN rejects invalid dates at capture with a one-cycle Error pulse.
module rtc_date_writer #(
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 2,
  parameter int T_HOLD = 1,
  parameter logic [7:0] ADDR_DIA = 8'h24,
  parameter logic [7:0] ADDR_MES = 8'h25,
  parameter logic [7:0] ADDR_ANO = 8'h26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Escribir,
  input  logic [7:0] DIA_in,
  input  logic [7:0] MES_in,
  input  logic [7:0] ANO_in,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       A_D,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       Ocupado,
  output logic       Listo,
  output logic       Error
);
  typedef enum logic [2:0] {IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE} state_t;
  localparam int TMAX = T_SETUP > T_PULSE ? (T_SETUP > T_HOLD ? T_SETUP : T_HOLD)
                                          : (T_PULSE > T_HOLD ? T_PULSE : T_HOLD);
  localparam int CW = $clog2(TMAX + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] dia_q, mes_q, ano_q, addr, dat;
  logic go, bad, last, a_ph, d_ph, stb;
  function automatic logic [CW-1:0] len(state_t s);
    return (s == A_SETUP || s == D_SETUP) ? CW'(T_SETUP - 1) :
           (s == A_STROBE || s == D_STROBE) ? CW'(T_PULSE - 1) :
           (s == A_HOLD || s == D_HOLD) ? CW'(T_HOLD - 1) : '0;
  endfunction
`ifdef RTC_BCD_CHECK_EN
  function automatic logic nib_bad(logic [7:0] b);
    return b[7:4] > 4'd9 || b[3:0] > 4'd9;
  endfunction
  assign bad = nib_bad(DIA_in) || nib_bad(MES_in) || nib_bad(ANO_in) ||
               MES_in == 8'h00 || MES_in > 8'h12 || DIA_in == 8'h00 || DIA_in > 8'h31;
  always_ff @(posedge CLK)
    if (RST) Error <= 1'b0;
    else Error <= go && bad;
`else
  assign bad = 1'b0;
  assign Error = 1'b0;
`endif
  assign go = state_q == IDLE && Escribir;
  assign last = cnt_q == '0;
  assign RD_n = 1'b1;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    unique case (state_q)
      IDLE: if (go && !bad) begin
        state_d = A_SETUP;
        idx_d = 2'd0;
      end
      A_SETUP:  if (last) state_d = A_STROBE;
      A_STROBE: if (last) state_d = A_HOLD;
      A_HOLD:   if (last) state_d = D_SETUP;
      D_SETUP:  if (last) state_d = D_STROBE;
      D_STROBE: if (last) state_d = D_HOLD;
      D_HOLD: if (last) begin
        state_d = idx_q < 2'd2 ? A_SETUP : DONE;
        idx_d = idx_q < 2'd2 ? idx_q + 2'd1 : idx_q;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? len(state_d) : (last ? '0 : cnt_q - 1'b1);
    a_ph = state_d == A_SETUP || state_d == A_STROBE || state_d == A_HOLD;
    d_ph = state_d == D_SETUP || state_d == D_STROBE || state_d == D_HOLD;
    stb = state_d == A_STROBE || state_d == D_STROBE;
    addr = idx_d == 2'd0 ? ADDR_DIA : idx_d == 2'd1 ? ADDR_MES : ADDR_ANO;
    dat = idx_d == 2'd0 ? dia_q : idx_d == 2'd1 ? mes_q : ano_q;
  end
  // Outputs are registered from the next state so they switch cleanly on phase boundaries.
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= 2'd0;
      dia_q <= 8'h00;
      mes_q <= 8'h00;
      ano_q <= 8'h00;
      AD_out <= 8'h00;
      AD_oe <= 1'b0;
      A_D <= 1'b1;
      CS_n <= 1'b1;
      WR_n <= 1'b1;
      Ocupado <= 1'b0;
      Listo <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (go) begin
        dia_q <= DIA_in;
        mes_q <= MES_in;
        ano_q <= ANO_in;
      end
      AD_out <= a_ph ? addr : d_ph ? dat : 8'h00;
      AD_oe <= a_ph || d_ph;
      A_D <= !a_ph;
      CS_n <= !stb;
      WR_n <= !stb;
      Ocupado <= a_ph || d_ph;
      Listo <= state_d == DONE;
    end
endmodule

// File: tb/tb_rtc_date_writer.sv
// tb_rtc_date_writer: directed vector bench with a bus monitor recording each address/data phase.
module tb_rtc_date_writer;
  logic clk = 0, rst, esc, sel;
  logic [7:0] dia, mes, ano;
  logic [7:0] ad1, ad2;
  logic oe1, a_d1, cs1, wr1, rd1, busy1, listo1, err1;
  logic oe2, a_d2, cs2, wr2, rd2, busy2, listo2, err2;
  logic [7:0] m_out;
  logic m_oe, m_ad, m_cs, m_wr, m_rd, m_busy, m_listo, m_err;
  int n_chk = 0, n_fail = 0;
  int busy, nlisto, listo_at, err_at;
  typedef struct {logic a_d; logic [7:0] b; int pre, wid, post;} rec_t;
  typedef struct {logic [7:0] d, m, a; bit bad; logic [47:0] exp;} vec_t;
  rec_t q[$];
  rec_t cur;
  vec_t tv[5];
  logic p_oe = 1'b0, p_ad = 1'b1;
  logic [7:0] p_out = 8'h00;
`ifdef RTC_BCD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  rtc_date_writer dut (.CLK(clk), .RST(rst), .Escribir(esc & ~sel), .DIA_in(dia), .MES_in(mes),
    .ANO_in(ano), .AD_out(ad1), .AD_oe(oe1), .A_D(a_d1), .CS_n(cs1), .WR_n(wr1), .RD_n(rd1),
    .Ocupado(busy1), .Listo(listo1), .Error(err1));
  rtc_date_writer #(.T_SETUP(2), .T_PULSE(3), .T_HOLD(2)) dut2 (.CLK(clk), .RST(rst),
    .Escribir(esc & sel), .DIA_in(dia), .MES_in(mes), .ANO_in(ano), .AD_out(ad2), .AD_oe(oe2),
    .A_D(a_d2), .CS_n(cs2), .WR_n(wr2), .RD_n(rd2), .Ocupado(busy2), .Listo(listo2), .Error(err2));

  assign m_out = sel ? ad2 : ad1;
  assign m_oe = sel ? oe2 : oe1;
  assign m_ad = sel ? a_d2 : a_d1;
  assign m_cs = sel ? cs2 : cs1;
  assign m_wr = sel ? wr2 : wr1;
  assign m_rd = sel ? rd2 : rd1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_listo = sel ? listo2 : listo1;
  assign m_err = sel ? err2 : err1;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A phase is a run of driven cycles with constant A_D/AD_out; count setup, strobe and hold within it.
  always @(negedge clk) begin
    if (!(m_oe && p_oe && m_ad == p_ad && m_out == p_out)) begin
      if (p_oe) q.push_back(cur);
      cur = '{m_ad, m_out, 0, 0, 0};
    end
    if (m_oe) begin
      if (!m_cs) cur.wid += 1;
      else if (cur.wid == 0) cur.pre += 1;
      else cur.post += 1;
    end
    if (!rst) begin
      chk("wr_follows_cs", m_wr, m_cs);
      chk("rd_n_high", m_rd, 1);
    end
    p_oe = m_oe;
    p_ad = m_ad;
    p_out = m_out;
  end

  task automatic run(input logic [7:0] d, m, a, input int n, input int again, input int rst_at,
                     input bit chg);
    busy = 0; nlisto = 0; listo_at = 0; err_at = 0;
    @(negedge clk);
    q.delete();
    dia = d; mes = m; ano = a; esc = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      esc = (c == again);
      rst = (c == rst_at);
      if (chg && c == 1) dia = 8'h01;
      if (m_busy) busy++;
      if (m_listo) begin
        nlisto++;
        if (listo_at == 0) listo_at = c;
      end
      if (m_err) err_at = c;
      if (rst_at != 0 && c == rst_at + 1)
        chk("rst_outputs", {m_out, m_oe, m_ad, m_cs, m_wr, m_busy, m_listo, m_err},
            {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic check_recs(input logic [47:0] exp, input int pre, wid, post);
    chk("phase_count", q.size(), 6);
    if (q.size() == 6)
      for (int j = 0; j < 6; j++) begin
        chk("bus_byte", q[j].b, exp[47-8*j -: 8]);
        chk("bus_a_d", q[j].a_d, j % 2);
        chk("setup_cycles", q[j].pre, pre);
        chk("strobe_cycles", q[j].wid, wid);
        chk("hold_cycles", q[j].post, post);
      end
  endtask

  initial begin
    rst = 1; esc = 0; sel = 0; dia = 0; mes = 0; ano = 0;
    tv[0] = '{8'h15, 8'h12, 8'h24, 1'b0, 48'h24_15_25_12_26_24};
    tv[1] = '{8'h01, 8'h01, 8'h00, 1'b0, 48'h24_01_25_01_26_00};
    tv[2] = '{8'h31, 8'h12, 8'h99, 1'b0, 48'h24_31_25_12_26_99};
    tv[3] = '{8'h15, 8'h13, 8'h24, CHK, 48'h24_15_25_13_26_24};
    tv[4] = '{8'h1A, 8'h05, 8'h24, CHK, 48'h24_1A_25_05_26_24};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ad1, oe1, a_d1, cs1, wr1, rd1, busy1, listo1, err1},
        {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {cs1, wr1, rd1, oe1, a_d1, busy1, cs2, busy2},
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    for (int i = 0; i < 5; i++) begin
      run(tv[i].d, tv[i].m, tv[i].a, 27, 0, 0, 0);
      if (tv[i].bad) begin
        chk("error_cycle", err_at, 1);
        chk("error_busy", busy, 0);
        chk("error_no_bus", q.size(), 0);
        chk("error_no_listo", nlisto, 0);
      end else begin
        chk("busy_cycles", busy, 24);
        chk("listo_cycle", listo_at, 25);
        chk("listo_count", nlisto, 1);
        chk("no_error", err_at, 0);
        check_recs(tv[i].exp, 1, 2, 1);
      end
    end
    run(8'h15, 8'h12, 8'h24, 27, 5, 0, 1);
    chk("ignored_busy", busy, 24);
    chk("ignored_listo", nlisto, 1);
    check_recs(48'h24_15_25_12_26_24, 1, 2, 1);
    run(8'h15, 8'h12, 8'h24, 14, 0, 10, 0);
    chk("rst_busy_cycles", busy, 10);
    chk("rst_no_listo", nlisto, 0);
    run(8'h07, 8'h08, 8'h09, 27, 0, 0, 0);
    chk("after_rst_busy", busy, 24);
    chk("after_rst_listo", listo_at, 25);
    check_recs(48'h24_07_25_08_26_09, 1, 2, 1);
    sel = 1;
    run(8'h15, 8'h12, 8'h24, 45, 0, 0, 0);
    chk("p7_busy_cycles", busy, 42);
    chk("p7_listo_cycle", listo_at, 43);
    check_recs(48'h24_15_25_12_26_24, 2, 3, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
